// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks a synchronous table ROM from a base address
// and streams its words out on valid/ready with a last-word marker.
module rom_stream_reader #(
    parameter int AW    = 8,
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   length,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_q,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t state;
    state_t state_nx;

    logic [AW-1:0] addr_q;
    logic [AW:0]   rem_q;
    logic          s1_v;
    logic          s1_last;
    logic          s2_v;
    logic          s2_last;
    logic          done_q;
    logic          done_nx;

    logic [DW-1:0] fifo_data [DEPTH];
    logic          fifo_last [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic [CW+1:0] inflight;

    logic first_issue;
    logic issue;
    logic credit_ok;
    logic push;
    logic pop;
    logic final_hs;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Words already owned by the reader: buffered plus both pipeline stages.
    assign inflight  = (CW+2)'(fifo_cnt) + (CW+2)'(s1_v) + (CW+2)'(s2_v);
    assign credit_ok = inflight < (CW+2)'(DEPTH);

    assign push      = s2_v;
    assign out_valid = (fifo_cnt != '0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = out_valid & fifo_last[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign final_hs  = pop & out_last;

    assign busy = (state != IDLE);
    assign done = done_q;

    // Control state and the registered completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= done_nx;
        end
    end

    // Next state, issue decisions and completion; abort overrides all.
    always_comb begin
        state_nx    = state;
        first_issue = 1'b0;
        issue       = 1'b0;
        done_nx     = 1'b0;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !done_q) begin
                        if (length == '0) begin
                            done_nx = 1'b1;
                        end else begin
                            first_issue = 1'b1;
                            state_nx    = (length == ONE) ? DRAIN : FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (credit_ok) begin
                        issue = 1'b1;
                        if (rem_q == ONE) begin
                            state_nx = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (final_hs) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Address/remaining counters and the two-stage read pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            addr_q   <= '0;
            rem_q    <= '0;
            s1_v     <= 1'b0;
            s1_last  <= 1'b0;
            s2_v     <= 1'b0;
            s2_last  <= 1'b0;
        end else if (abort) begin
            addr_q  <= '0;
            rem_q   <= '0;
            s1_v    <= 1'b0;
            s1_last <= 1'b0;
            s2_v    <= 1'b0;
            s2_last <= 1'b0;
        end else begin
            s2_v    <= s1_v;
            s2_last <= s1_last;
            s1_v    <= first_issue | issue;
            if (first_issue) begin
                rom_addr <= base_addr;
                addr_q   <= base_addr + AW'(1);
                rem_q    <= length - ONE;
                s1_last  <= (length == ONE);
            end else if (issue) begin
                rom_addr <= addr_q;
                addr_q   <= addr_q + AW'(1);
                rem_q    <= rem_q - ONE;
                s1_last  <= (rem_q == ONE);
            end else begin
                s1_last <= 1'b0;
            end
        end
    end

    // Prefetch FIFO; the credit check keeps pushes from ever finding it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else if (abort) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rom_q;
                fifo_last[wr_ptr] <= s2_last;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: drives rom_stream_reader against a one-cycle ROM
// and checks the streamed words against a transfer-level reference.
module tb_rom_stream_reader;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length    = '0;
    logic          busy;
    logic          done;
    logic          out_valid;
    logic          out_last;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic [DW-1:0] out_data;

    logic [DW-1:0] rom_mem [256];

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] got_d [$];
    logic          got_l [$];
    logic [AW-1:0] addrs [$];
    int first_valid;
    int done_at;
    int done_cnt;
    int hs;
    int stall_bad;
    int max_out;
    int busy_late;
    int valid_late;
    bit [5:0] pat = 6'b101001;

    rom_stream_reader #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom_mem[rom_addr];

    // Reference: word k of a transfer is the table entry at (base + k) mod 256.
    function automatic logic [DW-1:0] ref_word(input logic [7:0] b, input int k);
        logic [7:0] a;
        a = b + 8'(k);
        return {8'hA5, a};
    endfunction

    task automatic do_start(input logic [7:0] b, input logic [8:0] n, input logic ab);
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        length    = n;
        abort     = ab;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Runs the consumer side from the first cycle after the start edge and
    // records what the stream delivered; it makes no judgements itself.
    task automatic collect(input int max_cyc, input int rmode,
                           input int stop_hs, input int poke);
        logic          pv, pr, pl;
        logic [DW-1:0] pd;
        logic [AW-1:0] pa;
        int issued, out_n;
        got_d.delete();
        got_l.delete();
        addrs.delete();
        first_valid = 0; done_at = 0; done_cnt = 0; hs = 0;
        stall_bad = 0; max_out = 0; busy_late = 0; valid_late = 0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        pa = rom_addr;
        issued = 1;
        addrs.push_back(rom_addr);
        for (int i = 1; i <= max_cyc; i++) begin
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = pat[(i-1) % 6];
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            start = 1'b0;
            if (rom_addr != pa) begin
                issued++;
                addrs.push_back(rom_addr);
                pa = rom_addr;
            end
            out_n = issued - hs;
            if (out_n > max_out) max_out = out_n;
            if (pv && !pr) begin
                if (!out_valid || out_data !== pd || out_last !== pl) stall_bad++;
            end
            if (out_valid && first_valid == 0) first_valid = i;
            if (done_at != 0 && i > done_at) begin
                if (busy) busy_late++;
                if (out_valid) valid_late++;
            end
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = i;
            end
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                hs++;
            end
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
            if (poke == 1 && i == 5) begin
                start = 1'b1; base_addr = 8'h55; length = 9'd3;
            end
            if (poke == 2 && done && done_at == i) begin
                start = 1'b1; base_addr = 8'h33; length = 9'd2;
            end
            if (done_at != 0 && i >= done_at + 3) break;
            if (stop_hs != 0 && hs == stop_hs) break;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", out_last); end
        total++; if (rom_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", rom_addr); end
        total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int n;
        n = 4;
        out_ready = 1'b1;
        do_start(8'h10, 9'(n), 1'b0);
        collect(40, 0, 0, 0);
        total++; if (got_d.size() != n) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", got_d.size(), n); end
        for (int k = 0; k < n && k < got_d.size(); k++) begin
            total++;
            if (got_d[k] !== ref_word(8'h10, k) || got_l[k] !== (k == n-1)) begin
                bad++;
                $display("FAIL basic_word%0d got=%h/%b exp=%h/%b", k, got_d[k], got_l[k], ref_word(8'h10, k), (k == n-1));
            end
        end
        total++; if (first_valid != 3) begin bad++; $display("FAIL basic_first_valid got=%0d exp=3", first_valid); end
        total++; if (done_at != n + 3) begin bad++; $display("FAIL basic_done_at got=%0d exp=%0d", done_at, n + 3); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_wrap();
        int n;
        n = 4;
        out_ready = 1'b1;
        do_start(8'hFE, 9'(n), 1'b0);
        collect(40, 0, 0, 0);
        total++; if (got_d.size() != n) begin bad++; $display("FAIL wrap_count got=%0d exp=%0d", got_d.size(), n); end
        for (int k = 0; k < n && k < got_d.size(); k++) begin
            total++;
            if (got_d[k] !== ref_word(8'hFE, k) || got_l[k] !== (k == n-1)) begin
                bad++;
                $display("FAIL wrap_word%0d got=%h/%b exp=%h/%b", k, got_d[k], got_l[k], ref_word(8'hFE, k), (k == n-1));
            end
        end
        total++; if (addrs.size() != n) begin bad++; $display("FAIL wrap_addr_count got=%0d exp=%0d", addrs.size(), n); end
        for (int k = 0; k < n && k < addrs.size(); k++) begin
            total++;
            if (addrs[k] !== 8'(8'hFE + k)) begin
                bad++;
                $display("FAIL wrap_addr%0d got=%h exp=%h", k, addrs[k], 8'(8'hFE + k));
            end
        end
    endtask

    task automatic test_backpressure(input int n, input int rmode, input string tag);
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        do_start(b, 9'(n), 1'b0);
        collect(600, rmode, 0, 0);
        total++; if (got_d.size() != n) begin bad++; $display("FAIL %s_count got=%0d exp=%0d", tag, got_d.size(), n); end
        for (int k = 0; k < n && k < got_d.size(); k++) begin
            total++;
            if (got_d[k] !== ref_word(b, k) || got_l[k] !== (k == n-1)) begin
                bad++;
                $display("FAIL %s_word%0d got=%h/%b exp=%h/%b", tag, k, got_d[k], got_l[k], ref_word(b, k), (k == n-1));
            end
        end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL %s_stall_stable got=%0d exp=0", tag, stall_bad); end
        total++; if (max_out > DEPTH) begin bad++; $display("FAIL %s_outstanding got=%0d exp<=%0d", tag, max_out, DEPTH); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL %s_done_cnt got=%0d exp=1", tag, done_cnt); end
    endtask

    task automatic test_len0();
        int seen;
        out_ready = 1'b1;
        do_start(8'h40, 9'd0, 1'b0);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL len0_done got=%b exp=1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL len0_busy got=%b exp=0", busy); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy || out_valid) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL len0_quiet got=%0d exp=0", seen); end
    endtask

    task automatic test_len256();
        int n;
        n = 256;
        out_ready = 1'b1;
        do_start(8'h80, 9'(n), 1'b0);
        collect(400, 0, 0, 0);
        total++; if (got_d.size() != n) begin bad++; $display("FAIL len256_count got=%0d exp=%0d", got_d.size(), n); end
        for (int k = 0; k < n && k < got_d.size(); k++) begin
            total++;
            if (got_d[k] !== ref_word(8'h80, k) || got_l[k] !== (k == n-1)) begin
                bad++;
                $display("FAIL len256_word%0d got=%h/%b exp=%h/%b", k, got_d[k], got_l[k], ref_word(8'h80, k), (k == n-1));
            end
        end
        total++; if (done_at != n + 3) begin bad++; $display("FAIL len256_done_at got=%0d exp=%0d", done_at, n + 3); end
    endtask

    task automatic test_abort();
        logic [7:0] b;
        int seen;
        b = 8'($urandom_range(0, 255));
        out_ready = 1'b1;
        do_start(b, 9'd10, 1'b0);
        collect(40, 0, 3, 0);
        @(negedge clk);
        abort = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        total++; if (hs != 3) begin bad++; $display("FAIL abort_hs got=%0d exp=3", hs); end
        for (int k = 0; k < 3 && k < got_d.size(); k++) begin
            total++;
            if (got_d[k] !== ref_word(b, k)) begin
                bad++;
                $display("FAIL abort_word%0d got=%h exp=%h", k, got_d[k], ref_word(b, k));
            end
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy || out_valid) seen++;
            @(negedge clk);
        end
        total++; if (seen != 0) begin bad++; $display("FAIL abort_quiet got=%0d exp=0", seen); end

        out_ready = 1'b1;
        do_start(8'h00, 9'd2, 1'b0);
        collect(40, 0, 0, 0);
        total++; if (got_d.size() != 2) begin bad++; $display("FAIL restart_count got=%0d exp=2", got_d.size()); end
        for (int k = 0; k < 2 && k < got_d.size(); k++) begin
            total++;
            if (got_d[k] !== ref_word(8'h00, k) || got_l[k] !== (k == 1)) begin
                bad++;
                $display("FAIL restart_word%0d got=%h/%b exp=%h/%b", k, got_d[k], got_l[k], ref_word(8'h00, k), (k == 1));
            end
        end
        total++; if (done_at != 5) begin bad++; $display("FAIL restart_done_at got=%0d exp=5", done_at); end

        do_start(8'h20, 9'd5, 1'b1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy || out_valid) seen++;
            @(negedge clk);
        end
        total++; if (seen != 0) begin bad++; $display("FAIL abort_with_start got=%0d exp=0", seen); end
    endtask

    task automatic test_reset_mid();
        int n;
        out_ready = 1'b0;
        do_start(8'h30, 9'd8, 1'b0);
        repeat (4) @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre_valid got=%b exp=1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rstmid_last got=%b exp=0", out_last); end
        total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL rstmid_data got=%h exp=0000", out_data); end
        total++; if (rom_addr !== 8'h00) begin bad++; $display("FAIL rstmid_addr got=%h exp=00", rom_addr); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
        @(negedge clk);
        rst_n = 1'b1;
        n = 4;
        out_ready = 1'b1;
        do_start(8'h10, 9'(n), 1'b0);
        collect(40, 0, 0, 0);
        total++; if (got_d.size() != n) begin bad++; $display("FAIL rstmid_count got=%0d exp=%0d", got_d.size(), n); end
        for (int k = 0; k < n && k < got_d.size(); k++) begin
            total++;
            if (got_d[k] !== ref_word(8'h10, k) || got_l[k] !== (k == n-1)) begin
                bad++;
                $display("FAIL rstmid_word%0d got=%h/%b exp=%h/%b", k, got_d[k], got_l[k], ref_word(8'h10, k), (k == n-1));
            end
        end
        total++; if (first_valid != 3) begin bad++; $display("FAIL rstmid_first_valid got=%0d exp=3", first_valid); end
    endtask

    task automatic test_busy_start();
        int n;
        n = 6;
        out_ready = 1'b1;
        do_start(8'h20, 9'(n), 1'b0);
        collect(60, 0, 0, 1);
        total++; if (got_d.size() != n) begin bad++; $display("FAIL busystart_count got=%0d exp=%0d", got_d.size(), n); end
        for (int k = 0; k < n && k < got_d.size(); k++) begin
            total++;
            if (got_d[k] !== ref_word(8'h20, k) || got_l[k] !== (k == n-1)) begin
                bad++;
                $display("FAIL busystart_word%0d got=%h/%b exp=%h/%b", k, got_d[k], got_l[k], ref_word(8'h20, k), (k == n-1));
            end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL busystart_done_cnt got=%0d exp=1", done_cnt); end
        total++; if (busy_late + valid_late != 0) begin bad++; $display("FAIL busystart_after_done got=%0d exp=0", busy_late + valid_late); end

        do_start(8'h60, 9'd3, 1'b0);
        collect(60, 0, 0, 2);
        total++; if (got_d.size() != 3) begin bad++; $display("FAIL donestart_count got=%0d exp=3", got_d.size()); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL donestart_done_cnt got=%0d exp=1", done_cnt); end
        total++; if (busy_late + valid_late != 0) begin bad++; $display("FAIL donestart_after_done got=%0d exp=0", busy_late + valid_late); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = {8'hA5, 8'(i)};
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure(8, 1, "bp");
        for (int r = 0; r < 4; r++) begin
            test_backpressure($urandom_range(1, 24), 2, "rand");
        end
        test_len0();
        test_len256();
        test_abort();
        test_reset_mid();
        test_busy_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
